// File: rtl/vend_pkg.sv
// Shared types and default sizing for the vending controller and its front-end blocks.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } vend_state_t;

  localparam int DEF_NUM_ITEMS   = 4;
  localparam int DEF_CREDIT_W    = 8;
  localparam int DEF_MAX_CREDIT  = 200;
  localparam int DEF_TIMEOUT_CYC = 1000;

  // Counter width able to hold values 0..cyc inclusive.
  function automatic int count_width(input int cyc);
    return (cyc < 1) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/vend_price_table.sv
// Per-item price register file: one synchronous write port, two combinational read ports.
module vend_price_table #(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W  = 8,
  localparam int IW       = $clog2(NUM_ITEMS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                we,
  input  logic [IW-1:0]       waddr,
  input  logic [CREDIT_W-1:0] wdata,
  input  logic [IW-1:0]       raddr_a,
  output logic [CREDIT_W-1:0] rdata_a,
  input  logic [IW-1:0]       raddr_b,
  output logic [CREDIT_W-1:0] rdata_b
);

  logic [CREDIT_W-1:0] price_reg [NUM_ITEMS];

  generate
    for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_row
      always_ff @(posedge clk) begin
        if (!rstn) begin
          price_reg[gi] <= '0;
        end else if (we && (waddr == IW'(gi))) begin
          price_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  assign rdata_a = price_reg[raddr_a];
  assign rdata_b = price_reg[raddr_b];

endmodule

// File: rtl/multi_item_vend_ctrl.sv
// Multi-item vending controller: price table, coin accumulation, dispense/change
// handshakes, cancel and inactivity refund.
module multi_item_vend_ctrl
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS   = DEF_NUM_ITEMS,
  parameter int CREDIT_W    = DEF_CREDIT_W,
  parameter int MAX_CREDIT  = DEF_MAX_CREDIT,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int IW         = $clog2(NUM_ITEMS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cfg_mode,
  input  logic                cfg_we,
  input  logic [IW-1:0]       cfg_item,
  input  logic [CREDIT_W-1:0] cfg_price,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                sel_valid,
  input  logic [IW-1:0]       sel_item,
  input  logic                cancel,
  output logic                coin_reject,
  output logic                sel_reject,
  output logic                dispense_valid,
  output logic [IW-1:0]       dispense_item,
  input  logic                dispense_ready,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int TW = count_width(TIMEOUT_CYC);

  vend_state_t         state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic                sel_pend_reg, sel_pend_next;
  logic [IW-1:0]       sel_item_reg, sel_item_next;
  logic [IW-1:0]       disp_item_reg, disp_item_next;
  logic [CREDIT_W-1:0] disp_price_reg, disp_price_next;
  logic [TW-1:0]       timer_reg, timer_next;
  logic                coin_rej_reg, coin_rej_next;
  logic                sel_rej_reg, sel_rej_next;

  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W-1:0] pend_price;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] remainder;
  logic                vend_open, coin_ok, sel_ok, timeout, refund, can_vend;

  vend_price_table #(
    .NUM_ITEMS (NUM_ITEMS),
    .CREDIT_W  (CREDIT_W)
  ) u_price_table (
    .clk     (clk),
    .rstn    (rstn),
    .we      (cfg_we && cfg_mode && (state_reg == ST_IDLE)),
    .waddr   (cfg_item),
    .wdata   (cfg_price),
    .raddr_a (sel_item),
    .rdata_a (sel_price),
    .raddr_b (sel_item_reg),
    .rdata_b (pend_price)
  );

  // One bit wider so an overflowing coin still compares correctly against the cap.
  assign coin_sum  = {1'b0, credit_reg} + {1'b0, coin_value};
  assign remainder = credit_reg - disp_price_reg;
  assign vend_open = !cfg_mode && ((state_reg == ST_IDLE) || (state_reg == ST_CREDIT));
  assign coin_ok   = coin_valid && vend_open && !cancel
                     && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign sel_ok    = sel_valid && vend_open && (sel_price != '0);
  assign timeout   = (state_reg == ST_CREDIT) && !coin_ok && !sel_ok
                     && (timer_reg >= TW'(TIMEOUT_CYC - 1));
  assign refund    = ((state_reg == ST_IDLE) || (state_reg == ST_CREDIT)) && (cancel || timeout);
  assign can_vend  = (state_reg == ST_CREDIT) && sel_pend_reg && (credit_reg >= pend_price);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= ST_IDLE;
      credit_reg     <= '0;
      sel_pend_reg   <= 1'b0;
      sel_item_reg   <= '0;
      disp_item_reg  <= '0;
      disp_price_reg <= '0;
      timer_reg      <= '0;
      coin_rej_reg   <= 1'b0;
      sel_rej_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      credit_reg     <= credit_next;
      sel_pend_reg   <= sel_pend_next;
      sel_item_reg   <= sel_item_next;
      disp_item_reg  <= disp_item_next;
      disp_price_reg <= disp_price_next;
      timer_reg      <= timer_next;
      coin_rej_reg   <= coin_rej_next;
      sel_rej_reg    <= sel_rej_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    credit_next     = credit_reg;
    sel_pend_next   = sel_pend_reg;
    sel_item_next   = sel_item_reg;
    disp_item_next  = disp_item_reg;
    disp_price_next = disp_price_reg;
    timer_next      = timer_reg;
    coin_rej_next   = coin_valid && !coin_ok;
    sel_rej_next    = sel_valid && !sel_ok;

    if (coin_ok) credit_next = coin_sum[CREDIT_W-1:0];
    if (sel_ok) begin
      sel_pend_next = 1'b1;
      sel_item_next = sel_item;
    end

    case (state_reg)
      ST_IDLE, ST_CREDIT: begin
        if (refund) begin
          // Cancel and timeout share this path; a coin is never accepted here.
          sel_pend_next = 1'b0;
          timer_next    = '0;
          state_next    = (credit_reg != '0) ? ST_CHANGE : ST_IDLE;
        end else if (can_vend) begin
          disp_item_next  = sel_item_reg;
          disp_price_next = pend_price;
          timer_next      = '0;
          state_next      = ST_DISPENSE;
        end else if (state_reg == ST_IDLE) begin
          timer_next = '0;
          if (coin_ok || sel_ok) state_next = ST_CREDIT;
        end else begin
          timer_next = (coin_ok || sel_ok) ? '0 : timer_reg + 1'b1;
        end
      end
      ST_DISPENSE: begin
        if (dispense_ready) begin
          credit_next   = remainder;
          sel_pend_next = 1'b0;
          state_next    = (remainder != '0) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        if (change_ready) begin
          credit_next = '0;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    dispense_valid = (state_reg == ST_DISPENSE);
    change_valid   = (state_reg == ST_CHANGE);
    change_amount  = (state_reg == ST_CHANGE) ? credit_reg : '0;
    dispense_item  = disp_item_reg;
    coin_reject    = coin_rej_reg;
    sel_reject     = sel_rej_reg;
    credit         = credit_reg;
    busy           = (state_reg != ST_IDLE);
  end

endmodule

// File: tb/tb_multi_item_vend_ctrl.sv
// Directed scoreboard bench: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_multi_item_vend_ctrl;

  localparam int NI   = 4;
  localparam int CW   = 8;
  localparam int MAXC = 200;
  localparam int TOC  = 20;
  localparam int IW   = 2;

  localparam int K_COIN = 0;
  localparam int K_SEL  = 1;
  localparam int K_DISP = 2;
  localparam int K_CHG  = 3;

  typedef struct {
    int kind;
    int val;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cfg_mode, cfg_we;
  logic [IW-1:0] cfg_item;
  logic [CW-1:0] cfg_price;
  logic          coin_valid;
  logic [CW-1:0] coin_value;
  logic          sel_valid;
  logic [IW-1:0] sel_item;
  logic          cancel;
  logic          coin_reject, sel_reject;
  logic          dispense_valid;
  logic [IW-1:0] dispense_item;
  logic          dispense_ready;
  logic          change_valid;
  logic [CW-1:0] change_amount;
  logic          change_ready;
  logic [CW-1:0] credit;
  logic          busy;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  multi_item_vend_ctrl #(
    .NUM_ITEMS   (NI),
    .CREDIT_W    (CW),
    .MAX_CREDIT  (MAXC),
    .TIMEOUT_CYC (TOC)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .cfg_mode       (cfg_mode),
    .cfg_we         (cfg_we),
    .cfg_item       (cfg_item),
    .cfg_price      (cfg_price),
    .coin_valid     (coin_valid),
    .coin_value     (coin_value),
    .sel_valid      (sel_valid),
    .sel_item       (sel_item),
    .cancel         (cancel),
    .coin_reject    (coin_reject),
    .sel_reject     (sel_reject),
    .dispense_valid (dispense_valid),
    .dispense_item  (dispense_item),
    .dispense_ready (dispense_ready),
    .change_valid   (change_valid),
    .change_amount  (change_amount),
    .change_ready   (change_ready),
    .credit         (credit),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
    end else begin
      $display("[TB] ok   %s: %0d", name, act);
    end
  endtask

  task automatic push(input int kind, input int val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string name, input int kind, input int val);
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL %s: unexpected event value %0d, nothing expected", name, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        fails++;
        $display("[TB] FAIL %s: got kind %0d value %0d expected kind %0d value %0d",
                 name, kind, val, e.kind, e.val);
      end else begin
        $display("[TB] ok   %s: value %0d", name, val);
      end
    end
  endtask

  // Monitor: one pop per DUT output event.
  always @(negedge clk) begin
    if (coin_reject) pop_check("coin_reject", K_COIN, 0);
    if (sel_reject) pop_check("sel_reject", K_SEL, 0);
    if (dispense_valid && dispense_ready) pop_check("dispense", K_DISP, int'(dispense_item));
    if (change_valid && change_ready) pop_check("change", K_CHG, int'(change_amount));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int item, input int price);
    cfg_mode = 1'b1; cfg_we = 1'b1;
    cfg_item = IW'(item); cfg_price = CW'(price);
    tick();
    cfg_we = 1'b0; cfg_mode = 1'b0;
  endtask

  task automatic coin(input int val);
    coin_valid = 1'b1; coin_value = CW'(val);
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic sel(input int item);
    sel_valid = 1'b1; sel_item = IW'(item);
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    chk(name, int'(busy), 0);
  endtask

  task automatic wait_disp(input string name, input int max_cyc);
    int n = 0;
    while (!dispense_valid && n < max_cyc) begin
      tick();
      n++;
    end
    chk(name, int'(dispense_valid), 1);
  endtask

  initial begin
    rstn = 1'b0; cfg_mode = 1'b0; cfg_we = 1'b0; cfg_item = '0; cfg_price = '0;
    coin_valid = 1'b0; coin_value = '0; sel_valid = 1'b0; sel_item = '0; cancel = 1'b0;
    dispense_ready = 1'b1; change_ready = 1'b1;
    tick(); tick();
    rstn = 1'b1;
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_dispense_valid", int'(dispense_valid), 0);
    chk("rst_change_valid", int'(change_valid), 0);

    // Price 25 for item 2, 30 for item 1; three dimes then select 2 -> dispense 2, change 5.
    cfg_write(2, 25);
    cfg_write(1, 30);
    push(K_DISP, 2);
    push(K_CHG, 5);
    coin(10); coin(10); coin(10);
    chk("credit_30", int'(credit), 30);
    sel(2);
    wait_idle("a_idle", 30);
    chk("a_credit_0", int'(credit), 0);

    // Selection before coin; dispense held off for 3 cycles with item stable.
    dispense_ready = 1'b0;
    sel(1);
    chk("b_busy_after_sel", int'(busy), 1);
    coin(30);
    wait_disp("b_disp_valid", 10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_hold_valid", int'(dispense_valid), 1);
      chk("b_hold_item", int'(dispense_item), 1);
    end
    push(K_DISP, 1);
    dispense_ready = 1'b1;
    wait_idle("b_idle", 10);
    chk("b_credit_0", int'(credit), 0);

    // Disabled item, then overflow of the credit cap, then cancel refund of 195.
    push(K_SEL, 0);
    sel(3);
    tick();
    chk("c_idle_after_rej", int'(busy), 0);
    coin(100); coin(95);
    push(K_COIN, 0);
    coin(10);
    chk("c_credit_195", int'(credit), 195);
    push(K_CHG, 195);
    do_cancel();
    wait_idle("c_idle", 10);

    // Cancel refund and timeout refund of 20.
    coin(20);
    push(K_CHG, 20);
    do_cancel();
    wait_idle("d_cancel_idle", 10);
    coin(20);
    push(K_CHG, 20);
    wait_idle("d_timeout_idle", TOC + 20);
    chk("d_credit_0", int'(credit), 0);

    // Config mode blocks vending; price writes outside IDLE are dropped.
    cfg_mode = 1'b1;
    push(K_COIN, 0);
    push(K_SEL, 0);
    coin_valid = 1'b1; coin_value = 8'd10; sel_valid = 1'b1; sel_item = 2'd2;
    tick();
    coin_valid = 1'b0; sel_valid = 1'b0; cfg_mode = 1'b0;
    tick();
    chk("e_cfg_no_busy", int'(busy), 0);
    coin(10);
    cfg_mode = 1'b1; cfg_we = 1'b1; cfg_item = 2'd2; cfg_price = 8'd5;
    tick();
    cfg_mode = 1'b0; cfg_we = 1'b0;
    sel(2);
    tick(); tick(); tick();
    chk("e_no_dispense", int'(dispense_valid), 0);
    chk("e_credit_10", int'(credit), 10);
    push(K_CHG, 10);
    do_cancel();
    wait_idle("e_idle", 10);

    // Reset mid-dispense, then coin with cancel.
    dispense_ready = 1'b0;
    coin(30);
    sel(2);
    wait_disp("f_disp_valid", 10);
    rstn = 1'b0;
    tick();
    chk("f_rst_disp_valid", int'(dispense_valid), 0);
    chk("f_rst_change_valid", int'(change_valid), 0);
    chk("f_rst_credit", int'(credit), 0);
    chk("f_rst_busy", int'(busy), 0);
    rstn = 1'b1;
    dispense_ready = 1'b1;
    push(K_COIN, 0);
    coin_valid = 1'b1; coin_value = 8'd10; cancel = 1'b1;
    tick();
    coin_valid = 1'b0; cancel = 1'b0;
    tick(); tick();
    chk("f_coin_cancel_credit", int'(credit), 0);
    chk("f_coin_cancel_busy", int'(busy), 0);

    tick(); tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
